// File: rtl/avalon_bus_arbiter_if.sv
// Requester-side and Avalon-side signals of avalon_bus_arbiter in one bundle.
// master: the arbiter's view; slave: the requesters and the Avalon target seen from outside.
interface avalon_bus_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        busy;
  logic        bus_err;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic        waitrequest;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;

  modport master (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, waitrequest, readdata,
    output if_rdata, if_done, d_rdata, d_done, busy, bus_err,
           address, read, write, writedata, byteenable
  );

  modport slave (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, waitrequest, readdata,
    input  if_rdata, if_done, d_rdata, d_done, busy, bus_err,
           address, read, write, writedata, byteenable
  );
endinterface

// File: rtl/avalon_bus_arbiter.sv
// Avalon-MM arbiter sharing one master port between instruction fetch and data access.
// Define ARB_TIMEOUT_EN to abort transfers stalled for TIMEOUT_CYCLES cycles and raise a sticky bus_err.
module avalon_bus_arbiter #(
  parameter int DATA_PRIORITY  = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                  clk,
  input logic                  reset,
  avalon_bus_arbiter_if.master bus
);

  // state | meaning
  // IDLE  | sample requests, grant and launch the strobe on the edge
  // BUS   | strobe held until waitrequest drops
  // RDATA | readdata valid, captured into the granted requester
  // DONE  | one-cycle done pulse to the granted requester
  typedef enum logic [1:0] {IDLE, BUS, RDATA, DONE} state_t;

  state_t      state_q, state_d;
  logic        gnt_data_q, gnt_data_d;
  logic        rr_data_q, rr_data_d;
  logic        take_data;
  logic [31:0] address_q, address_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic [31:0] writedata_q, writedata_d;
  logic [3:0]  byteenable_q, byteenable_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        if_done_q, if_done_d;
  logic        d_done_q, d_done_d;
  logic        busy_q;
  logic        unused_bits;
`ifdef ARB_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [TW-1:0] stall_q, stall_d;
  logic          bus_err_q, bus_err_d;
`endif

  always_comb begin
    state_d      = state_q;
    gnt_data_d   = gnt_data_q;
    rr_data_d    = rr_data_q;
    take_data    = 1'b0;
    address_d    = address_q;
    read_d       = read_q;
    write_d      = write_q;
    writedata_d  = writedata_q;
    byteenable_d = byteenable_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    if_done_d    = 1'b0;
    d_done_d     = 1'b0;
`ifdef ARB_TIMEOUT_EN
    stall_d      = stall_q;
    bus_err_d    = bus_err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.if_req || bus.d_req) begin
          if (bus.if_req && bus.d_req) take_data = (DATA_PRIORITY != 0) ? 1'b1 : rr_data_q;
          else                         take_data = bus.d_req;
          gnt_data_d = take_data;
          rr_data_d  = ~take_data;
          state_d    = BUS;
          if (take_data) begin
            address_d    = {bus.d_addr[31:2], 2'b00};
            read_d       = ~bus.d_we;
            write_d      = bus.d_we;
            byteenable_d = bus.d_be;
            writedata_d  = bus.d_wdata;
          end else begin
            address_d    = {bus.if_addr[31:2], 2'b00};
            read_d       = 1'b1;
            write_d      = 1'b0;
            byteenable_d = 4'b1111;
          end
`ifdef ARB_TIMEOUT_EN
          stall_d = TW'(TIMEOUT_CYCLES);
`endif
        end
      end
      BUS: begin
        if (!bus.waitrequest) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          state_d = read_q ? RDATA : DONE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (stall_q <= TW'(1)) begin
          read_d    = 1'b0;
          write_d   = 1'b0;
          state_d   = DONE;
          bus_err_d = 1'b1;
        end else begin
          stall_d = stall_q - TW'(1);
        end
`endif
      end
      RDATA: begin
        if (gnt_data_q) d_rdata_d  = bus.readdata;
        else            if_rdata_d = bus.readdata;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // done is registered, so it is raised on the edge that enters DONE
    if (state_d == DONE && state_q != DONE) begin
      if_done_d = ~gnt_data_q;
      d_done_d  = gnt_data_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      gnt_data_q   <= 1'b0;
      rr_data_q    <= 1'b0;
      address_q    <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      writedata_q  <= '0;
      byteenable_q <= '0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      if_done_q    <= 1'b0;
      d_done_q     <= 1'b0;
      busy_q       <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      stall_q      <= '0;
      bus_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      gnt_data_q   <= gnt_data_d;
      rr_data_q    <= rr_data_d;
      address_q    <= address_d;
      read_q       <= read_d;
      write_q      <= write_d;
      writedata_q  <= writedata_d;
      byteenable_q <= byteenable_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      if_done_q    <= if_done_d;
      d_done_q     <= d_done_d;
      busy_q       <= (state_d != IDLE);
`ifdef ARB_TIMEOUT_EN
      stall_q      <= stall_d;
      bus_err_q    <= bus_err_d;
`endif
    end
  end

  assign bus.address    = address_q;
  assign bus.read       = read_q;
  assign bus.write      = write_q;
  assign bus.writedata  = writedata_q;
  assign bus.byteenable = byteenable_q;
  assign bus.if_rdata   = if_rdata_q;
  assign bus.d_rdata    = d_rdata_q;
  assign bus.if_done    = if_done_q;
  assign bus.d_done     = d_done_q;
  assign bus.busy       = busy_q;
`ifdef ARB_TIMEOUT_EN
  assign bus.bus_err    = bus_err_q;
`else
  assign bus.bus_err    = 1'b0;
`endif

  // word-aligned bus: byte-offset address bits are dropped by design
  assign unused_bits = &{1'b0, bus.if_addr[1:0], bus.d_addr[1:0], (TIMEOUT_CYCLES != 0)};

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// Directed scoreboard bench for avalon_bus_arbiter: instance a uses data priority, instance b round-robin.
// With ARB_TIMEOUT_EN defined, instance b (TIMEOUT_CYCLES=4) is also driven into a stall timeout.
module tb_avalon_bus_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  avalon_bus_arbiter_if bus_a ();
  avalon_bus_arbiter_if bus_b ();

  avalon_bus_arbiter #(.DATA_PRIORITY(1), .TIMEOUT_CYCLES(255)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  avalon_bus_arbiter #(.DATA_PRIORITY(0), .TIMEOUT_CYCLES(4))   dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  typedef struct packed {
    logic        is_data;
    logic [31:0] if_rd;
    logic [31:0] d_rd;
    int          cyc;
  } exp_t;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;
  logic [31:0] m_if_a = '0, m_d_a = '0, m_if_b = '0, m_d_b = '0;

  // Avalon target models: stall count per transfer, readdata valid only the cycle after accept
  int stall_a = 0, stall_b = 0, cnt_a = 0, cnt_b = 0;
  logic stuck_a = 1'b0, stuck_b = 1'b0;
  logic act_a = 1'b0, act_b = 1'b0, rdp_a = 1'b0, rdp_b = 1'b0;
  logic [31:0] mem_a = '0, mem_b = '0;

  always @(negedge clk) begin
    bus_a.readdata = 32'h0BAD0BAD;
    if (rdp_a) begin bus_a.readdata = mem_a; rdp_a = 1'b0; end
    if (bus_a.read || bus_a.write) begin
      if (!act_a) begin act_a = 1'b1; cnt_a = 0; end
      bus_a.waitrequest = stuck_a || (cnt_a < stall_a);
      cnt_a++;
      if (!bus_a.waitrequest) rdp_a = bus_a.read;
    end else begin
      act_a = 1'b0;
      bus_a.waitrequest = stuck_a;
    end
  end

  always @(negedge clk) begin
    bus_b.readdata = 32'h0BAD0BAD;
    if (rdp_b) begin bus_b.readdata = mem_b; rdp_b = 1'b0; end
    if (bus_b.read || bus_b.write) begin
      if (!act_b) begin act_b = 1'b1; cnt_b = 0; end
      bus_b.waitrequest = stuck_b || (cnt_b < stall_b);
      cnt_b++;
      if (!bus_b.waitrequest) rdp_b = bus_b.read;
    end else begin
      act_b = 1'b0;
      bus_b.waitrequest = stuck_b;
    end
  end

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input int sel, input logic is_data, input logic is_read,
                      input logic [31:0] rd, input int c);
    exp_t e;
    if (sel == 0) begin
      if (is_read && is_data)  m_d_a  = rd;
      if (is_read && !is_data) m_if_a = rd;
      e.is_data = is_data; e.if_rd = m_if_a; e.d_rd = m_d_a; e.cyc = c;
      q_a.push_back(e);
    end else begin
      if (is_read && is_data)  m_d_b  = rd;
      if (is_read && !is_data) m_if_b = rd;
      e.is_data = is_data; e.if_rd = m_if_b; e.d_rd = m_d_b; e.cyc = c;
      q_b.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (reset && (bus_a.if_done || bus_a.d_done)) begin
      check32("a_done_expected", 32'(q_a.size() != 0), 32'd1);
      if (q_a.size() != 0) begin
        e_a = q_a.pop_front();
        check32("a_done_kind", {30'd0, bus_a.if_done, bus_a.d_done}, e_a.is_data ? 32'd1 : 32'd2);
        check32("a_done_cycle", cyc, e_a.cyc);
        check32("a_if_rdata", bus_a.if_rdata, e_a.if_rd);
        check32("a_d_rdata", bus_a.d_rdata, e_a.d_rd);
      end
    end
    if (reset && (bus_b.if_done || bus_b.d_done)) begin
      check32("b_done_expected", 32'(q_b.size() != 0), 32'd1);
      if (q_b.size() != 0) begin
        e_b = q_b.pop_front();
        check32("b_done_kind", {30'd0, bus_b.if_done, bus_b.d_done}, e_b.is_data ? 32'd1 : 32'd2);
        check32("b_done_cycle", cyc, e_b.cyc);
        check32("b_if_rdata", bus_b.if_rdata, e_b.if_rd);
        check32("b_d_rdata", bus_b.d_rdata, e_b.d_rd);
      end
    end
  end

  task automatic neg_at(input int c);
    while (cyc < c) begin @(posedge clk); #1; end
    @(negedge clk);
  endtask

  task automatic req_fetch(input int sel, input logic [31:0] addr);
    if (sel == 0) begin bus_a.if_req = 1'b1; bus_a.if_addr = addr; end
    else          begin bus_b.if_req = 1'b1; bus_b.if_addr = addr; end
  endtask

  task automatic req_data(input int sel, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be);
    if (sel == 0) begin
      bus_a.d_req = 1'b1; bus_a.d_we = we; bus_a.d_addr = addr; bus_a.d_wdata = wdata; bus_a.d_be = be;
    end else begin
      bus_b.d_req = 1'b1; bus_b.d_we = we; bus_b.d_addr = addr; bus_b.d_wdata = wdata; bus_b.d_be = be;
    end
  endtask

  initial begin
    int r;
    bus_a.if_req = 1'b0; bus_a.if_addr = '0; bus_a.d_req = 1'b0; bus_a.d_we = 1'b0;
    bus_a.d_addr = '0; bus_a.d_wdata = '0; bus_a.d_be = '0;
    bus_b.if_req = 1'b0; bus_b.if_addr = '0; bus_b.d_req = 1'b0; bus_b.d_we = 1'b0;
    bus_b.d_addr = '0; bus_b.d_wdata = '0; bus_b.d_be = '0;
    repeat (3) @(posedge clk);
    #1;
    check32("rst_a_ctrl", 32'({bus_a.read, bus_a.write, bus_a.byteenable, bus_a.busy,
                               bus_a.if_done, bus_a.d_done, bus_a.bus_err}), 32'd0);
    check32("rst_a_address", bus_a.address, 32'd0);
    check32("rst_a_writedata", bus_a.writedata, 32'd0);
    check32("rst_a_if_rdata", bus_a.if_rdata, 32'd0);
    check32("rst_a_d_rdata", bus_a.d_rdata, 32'd0);
    check32("rst_b_ctrl", 32'({bus_b.read, bus_b.write, bus_b.byteenable, bus_b.busy,
                               bus_b.if_done, bus_b.d_done, bus_b.bus_err}), 32'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // fetch, zero stall
    r = cyc; stall_a = 0; mem_a = 32'h24020005;
    req_fetch(0, 32'hBFC00000);
    push(0, 1'b0, 1'b1, 32'h24020005, r + 3);
    neg_at(r);
    check32("t1_idle_busy", 32'(bus_a.busy), 32'd0);
    neg_at(r + 1);
    check32("t1_strobe", 32'({bus_a.read, bus_a.write}), 32'b10);
    check32("t1_address", bus_a.address, 32'hBFC00000);
    check32("t1_be", 32'(bus_a.byteenable), 32'hF);
    check32("t1_busy", 32'(bus_a.busy), 32'd1);
    neg_at(r + 2);
    check32("t1_strobe_drop", 32'({bus_a.read, bus_a.write}), 32'b00);
    neg_at(r + 3);
    @(posedge clk); #1; bus_a.if_req = 1'b0;

    // data write, three stall cycles; inputs changed mid-transfer must be ignored
    r = cyc; stall_a = 3;
    req_data(0, 1'b1, 32'h00001006, 32'hDEADBEEF, 4'b0011);
    push(0, 1'b1, 1'b0, 32'h0, r + 5);
    for (int k = 1; k <= 4; k++) begin
      neg_at(r + k);
      check32("t2_strobe", 32'({bus_a.read, bus_a.write}), 32'b01);
      check32("t2_address", bus_a.address, 32'h00001004);
      check32("t2_writedata", bus_a.writedata, 32'hDEADBEEF);
      check32("t2_be", 32'(bus_a.byteenable), 32'b0011);
      if (k == 2) begin bus_a.d_addr = 32'h55555555; bus_a.d_wdata = 32'h0; end
    end
    neg_at(r + 5);
    check32("t2_strobe_drop", 32'({bus_a.read, bus_a.write}), 32'b00);
    @(posedge clk); #1; bus_a.d_req = 1'b0;

    // simultaneous requests, data priority: data write first, then fetch
    r = cyc; stall_a = 0; mem_a = 32'h11112222;
    req_fetch(0, 32'h00000107);
    req_data(0, 1'b1, 32'h00002000, 32'h12345678, 4'b1111);
    push(0, 1'b1, 1'b0, 32'h0, r + 2);
    push(0, 1'b0, 1'b1, 32'h11112222, r + 6);
    neg_at(r + 1);
    check32("t3_data_first", 32'({bus_a.read, bus_a.write}), 32'b01);
    check32("t3_data_addr", bus_a.address, 32'h00002000);
    neg_at(r + 2);
    @(posedge clk); #1; bus_a.d_req = 1'b0;
    neg_at(r + 4);
    check32("t3_fetch_next", 32'({bus_a.read, bus_a.write}), 32'b10);
    check32("t3_fetch_addr", bus_a.address, 32'h00000104);
    neg_at(r + 6);
    @(posedge clk); #1; bus_a.if_req = 1'b0;

    // data read, five stall cycles, zero byte enables still issued
    r = cyc; stall_a = 5; mem_a = 32'h0000CAFE;
    req_data(0, 1'b0, 32'h00003000, 32'h0, 4'b0000);
    push(0, 1'b1, 1'b1, 32'h0000CAFE, r + 8);
    for (int k = 1; k <= 6; k++) begin
      neg_at(r + k);
      check32("t4_strobe", 32'({bus_a.read, bus_a.write}), 32'b10);
      check32("t4_address", bus_a.address, 32'h00003000);
      check32("t4_be", 32'(bus_a.byteenable), 32'b0000);
      if (k == 3) begin bus_a.d_addr = 32'hFFFF0000; bus_a.d_we = 1'b1; end
    end
    neg_at(r + 7);
    check32("t4_rdata_phase", 32'({bus_a.read, bus_a.write, bus_a.busy}), 32'b001);
    neg_at(r + 8);
    @(posedge clk); #1; bus_a.d_req = 1'b0; bus_a.d_we = 1'b0;

    // reset pulsed while a fetch is stalled in BUS
    r = cyc; stall_a = 10;
    req_fetch(0, 32'h00000400);
    neg_at(r + 2);
    check32("t5_pre_strobe", 32'(bus_a.read), 32'd1);
    #1 reset = 1'b0;
    #1;
    check32("t5_rst_strobe", 32'({bus_a.read, bus_a.write}), 32'b00);
    check32("t5_rst_busy", 32'(bus_a.busy), 32'd0);
    check32("t5_rst_if_rdata", bus_a.if_rdata, 32'd0);
    check32("t5_rst_d_rdata", bus_a.d_rdata, 32'd0);
    bus_a.if_req = 1'b0; stall_a = 0;
    m_if_a = '0; m_d_a = '0; m_if_b = '0; m_d_b = '0;
    @(negedge clk); reset = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    check32("t5_post_idle", 32'({bus_a.read, bus_a.write, bus_a.busy}), 32'b000);
    r = cyc; mem_a = 32'h87654321;
    req_fetch(0, 32'h00000800);
    push(0, 1'b0, 1'b1, 32'h87654321, r + 3);
    neg_at(r + 1);
    check32("t5_new_addr", bus_a.address, 32'h00000800);
    neg_at(r + 3);
    @(posedge clk); #1; bus_a.if_req = 1'b0;

    // round-robin: both -> fetch, data; fetch alone; both -> data, fetch
    r = cyc; mem_b = 32'hF0F0F0F0;
    req_fetch(1, 32'h00000010);
    req_data(1, 1'b1, 32'h00000020, 32'hA5A5A5A5, 4'b1100);
    push(1, 1'b0, 1'b1, 32'hF0F0F0F0, r + 3);
    push(1, 1'b1, 1'b0, 32'h0, r + 6);
    neg_at(r + 1);
    check32("t6_fetch_first", 32'({bus_b.read, bus_b.write}), 32'b10);
    neg_at(r + 3);
    @(posedge clk); #1; bus_b.if_req = 1'b0;
    neg_at(r + 5);
    check32("t6_data_strobe", 32'({bus_b.read, bus_b.write}), 32'b01);
    check32("t6_data_be", 32'(bus_b.byteenable), 32'b1100);
    check32("t6_data_wdata", bus_b.writedata, 32'hA5A5A5A5);
    neg_at(r + 6);
    @(posedge clk); #1; bus_b.d_req = 1'b0;

    r = cyc; mem_b = 32'h0A0A0A0A;
    req_fetch(1, 32'h00000014);
    push(1, 1'b0, 1'b1, 32'h0A0A0A0A, r + 3);
    neg_at(r + 3);
    @(posedge clk); #1; bus_b.if_req = 1'b0;

    r = cyc; mem_b = 32'h13579BDF;
    req_fetch(1, 32'h00000018);
    req_data(1, 1'b0, 32'h0000001C, 32'h0, 4'b1111);
    push(1, 1'b1, 1'b1, 32'h13579BDF, r + 3);
    push(1, 1'b0, 1'b1, 32'h2468ACE0, r + 7);
    neg_at(r + 1);
    check32("t6_rr_data_addr", bus_b.address, 32'h0000001C);
    neg_at(r + 3);
    mem_b = 32'h2468ACE0;
    @(posedge clk); #1; bus_b.d_req = 1'b0;
    neg_at(r + 7);
    @(posedge clk); #1; bus_b.if_req = 1'b0;

`ifdef ARB_TIMEOUT_EN
    // stuck waitrequest: abort after four stall cycles, sticky bus_err
    r = cyc; stuck_b = 1'b1;
    req_fetch(1, 32'h00000040);
    push(1, 1'b0, 1'b0, 32'h0, r + 5);
    for (int k = 1; k <= 4; k++) begin
      neg_at(r + k);
      check32("t7_stall_strobe", 32'(bus_b.read), 32'd1);
      check32("t7_stall_err", 32'(bus_b.bus_err), 32'd0);
    end
    neg_at(r + 5);
    check32("t7_abort_strobe", 32'({bus_b.read, bus_b.write}), 32'b00);
    check32("t7_abort_err", 32'(bus_b.bus_err), 32'd1);
    @(posedge clk); #1; bus_b.if_req = 1'b0; stuck_b = 1'b0;
    r = cyc;
    req_data(1, 1'b1, 32'h00000050, 32'h0F0F0F0F, 4'b1111);
    push(1, 1'b1, 1'b0, 32'h0, r + 2);
    neg_at(r + 2);
    check32("t7_err_sticky", 32'(bus_b.bus_err), 32'd1);
    @(posedge clk); #1; bus_b.d_req = 1'b0;
`else
    check32("no_timeout_err_a", 32'(bus_a.bus_err), 32'd0);
    check32("no_timeout_err_b", 32'(bus_b.bus_err), 32'd0);
`endif

    repeat (3) begin @(posedge clk); #1; end
    check32("a_sb_drained", 32'(q_a.size()), 32'd0);
    check32("b_sb_drained", 32'(q_b.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
